// File: rtl/csb_arbiter_pkg.sv
// csb_pkg: shared CSB widths, arbiter state encoding and request record
package csb_pkg;
  localparam int CSB_ADDR_W = 16;
  localparam int CSB_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;
  typedef struct packed {
    logic [CSB_ADDR_W-1:0] addr;
    logic [CSB_DATA_W-1:0] wdat;
    logic                  write;
    logic                  nposted;
  } csb_req_t;
endpackage

// File: rtl/csb_arbiter_if.sv
// csb_arbiter_if: bundle of both requester ports plus the CSB slave port
// slave modport = arbiter view; master modport = requesters/CSB model view
interface csb_arbiter_if;
  import csb_pkg::*;
  logic                  m0_req_valid, m0_req_ready, m0_req_write, m0_req_nposted;
  logic [CSB_ADDR_W-1:0] m0_req_addr;
  logic [CSB_DATA_W-1:0] m0_req_wdat;
  logic                  m0_rsp_valid, m0_rsp_err;
  logic [CSB_DATA_W-1:0] m0_rsp_data;
  logic                  m1_req_valid, m1_req_ready, m1_req_write, m1_req_nposted;
  logic [CSB_ADDR_W-1:0] m1_req_addr;
  logic [CSB_DATA_W-1:0] m1_req_wdat;
  logic                  m1_rsp_valid, m1_rsp_err;
  logic [CSB_DATA_W-1:0] m1_rsp_data;
  logic                  csb2nvdla_valid, csb2nvdla_ready, csb2nvdla_write, csb2nvdla_nposted;
  logic [CSB_ADDR_W-1:0] csb2nvdla_addr;
  logic [CSB_DATA_W-1:0] csb2nvdla_wdat;
  logic                  nvdla2csb_valid, nvdla2csb_wr_complete;
  logic [CSB_DATA_W-1:0] nvdla2csb_data;
  modport slave (
    input  m0_req_valid, m0_req_addr, m0_req_wdat, m0_req_write, m0_req_nposted,
    output m0_req_ready, m0_rsp_valid, m0_rsp_data, m0_rsp_err,
    input  m1_req_valid, m1_req_addr, m1_req_wdat, m1_req_write, m1_req_nposted,
    output m1_req_ready, m1_rsp_valid, m1_rsp_data, m1_rsp_err,
    output csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write, csb2nvdla_nposted,
    input  csb2nvdla_ready, nvdla2csb_valid, nvdla2csb_data, nvdla2csb_wr_complete
  );
  modport master (
    output m0_req_valid, m0_req_addr, m0_req_wdat, m0_req_write, m0_req_nposted,
    input  m0_req_ready, m0_rsp_valid, m0_rsp_data, m0_rsp_err,
    output m1_req_valid, m1_req_addr, m1_req_wdat, m1_req_write, m1_req_nposted,
    input  m1_req_ready, m1_rsp_valid, m1_rsp_data, m1_rsp_err,
    input  csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write, csb2nvdla_nposted,
    output csb2nvdla_ready, nvdla2csb_valid, nvdla2csb_data, nvdla2csb_wr_complete
  );
endinterface

// File: rtl/csb_rr_arb2.sv
// csb_rr_arb2: 2-way round-robin grant with a last-grant register
// ports: clk, reset, i_req (valids), i_en (commit grant), o_gnt (one-hot), o_win (index)
module csb_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt,
  output logic       o_win
);
  logic r_last;
  // requester 1 wins alone, or on a tie when requester 0 had the last grant
  assign o_win = i_req[1] & (~i_req[0] | ~r_last);
  assign o_gnt = {o_win, i_req[0] & ~o_win};
  always_ff @(posedge clk) begin
    if (reset) r_last <= 1'b1;
    else if (i_en) r_last <= o_win;
  end
endmodule

// File: rtl/csb_arbiter.sv
// csb_arbiter: two-requester CSB arbiter with one outstanding response and timeout
// ports: clk, reset (sync, active-high), bus (csb_arbiter_if.slave: requester 0/1
// request+response, CSB request/response), stray_rsp (sticky unexpected response), busy
module csb_arbiter
  import csb_pkg::*;
#(
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter logic [CSB_DATA_W-1:0] ERR_DATA       = 32'hDEAD_0BAD
) (
  input  logic                clk,
  input  logic                reset,
  csb_arbiter_if.slave        bus,
  output logic                stray_rsp,
  output logic                busy
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  state_t                r_state, w_next;
  csb_req_t              r_req, w_sel;
  logic                  r_owner;
  logic [CW-1:0]         r_cnt;
  logic [1:0]            r_rsp_valid;
  logic [CSB_DATA_W-1:0] r_rsp_data;
  logic                  r_rsp_err, r_stray;
  logic [1:0]            w_gnt;
  logic                  w_win, w_idle, w_acc, w_posted;
  logic                  w_rd_done, w_wr_done, w_done, w_tmo, w_stray;
  csb_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .i_req ({bus.m1_req_valid, bus.m0_req_valid}),
    .i_en  (w_acc),
    .o_gnt (w_gnt),
    .o_win (w_win)
  );
  assign w_idle = r_state == IDLE;
  assign w_acc = w_idle & (bus.m0_req_valid | bus.m1_req_valid);
  assign w_sel = w_win ? {bus.m1_req_addr, bus.m1_req_wdat, bus.m1_req_write, bus.m1_req_nposted}
                       : {bus.m0_req_addr, bus.m0_req_wdat, bus.m0_req_write, bus.m0_req_nposted};
  assign w_posted = r_req.write & ~r_req.nposted;
  // only the completion type matching the outstanding request counts
  assign w_rd_done = r_state == WAIT_RSP & ~r_req.write & bus.nvdla2csb_valid;
  assign w_wr_done = r_state == WAIT_RSP & r_req.write & bus.nvdla2csb_wr_complete;
  assign w_done = w_rd_done | w_wr_done;
  // a completion in the limit cycle beats the timeout
  assign w_tmo = r_state == WAIT_RSP & ~w_done & r_cnt == CW'(TIMEOUT_CYCLES - 1);
  assign w_stray = (bus.nvdla2csb_valid & ~w_rd_done) | (bus.nvdla2csb_wr_complete & ~w_wr_done);
  always_comb begin
    w_next = w_idle ? (w_acc ? ISSUE : IDLE)
           : r_state == ISSUE ? (!bus.csb2nvdla_ready ? ISSUE : w_posted ? IDLE : WAIT_RSP)
           : (w_done | w_tmo) ? IDLE : WAIT_RSP;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_owner     <= 1'b0;
      r_cnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_stray     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_req   <= w_sel;
        r_owner <= w_win;
      end
      r_cnt       <= r_state == WAIT_RSP ? r_cnt + 1'b1 : '0;
      r_rsp_valid <= {r_owner, ~r_owner} & {2{w_done | w_tmo}};
      r_rsp_data  <= w_rd_done ? bus.nvdla2csb_data : w_tmo ? ERR_DATA : '0;
      r_rsp_err   <= w_tmo;
      r_stray     <= r_stray | w_stray;
    end
  end
  assign bus.m0_req_ready = w_idle & w_gnt[0];
  assign bus.m1_req_ready = w_idle & w_gnt[1];
  // response data/err are gated so the non-owner always sees zeros
  assign bus.m0_rsp_valid = r_rsp_valid[0];
  assign bus.m0_rsp_data = r_rsp_valid[0] ? r_rsp_data : '0;
  assign bus.m0_rsp_err = r_rsp_valid[0] & r_rsp_err;
  assign bus.m1_rsp_valid = r_rsp_valid[1];
  assign bus.m1_rsp_data = r_rsp_valid[1] ? r_rsp_data : '0;
  assign bus.m1_rsp_err = r_rsp_valid[1] & r_rsp_err;
  assign bus.csb2nvdla_valid = r_state == ISSUE;
  assign bus.csb2nvdla_addr = r_req.addr;
  assign bus.csb2nvdla_wdat = r_req.wdat;
  assign bus.csb2nvdla_write = r_req.write;
  assign bus.csb2nvdla_nposted = r_req.nposted;
  assign stray_rsp = r_stray;
  assign busy = ~w_idle;
endmodule

// File: tb/tb_csb_arbiter.sv
// tb_csb_arbiter: directed and random checks of csb_arbiter against a transaction model
module tb_csb_arbiter;
  import csb_pkg::*;
  localparam int T = 16;
  localparam logic [31:0] ERR = 32'hDEAD_0BAD;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stray_rsp, busy;
  int n_chk = 0, n_pass = 0;
  csb_arbiter_if bus();
  csb_arbiter #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERR)) dut (
    .clk(clk), .reset(reset), .bus(bus), .stray_rsp(stray_rsp), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // transaction-level model: a held request, an awaited response with an absolute
  // deadline cycle, a response scheduled for the next cycle, and the sticky stray flag
  int m_last = 1, m_owner = 0, m_rsp_to = -1;
  bit m_hold = 0, m_wait = 0, m_wr = 0, m_np = 0, m_re = 0, m_stray = 0;
  logic [15:0] m_addr = '0;
  logic [31:0] m_wdat = '0, m_rd = '0;
  longint cyc = 0, m_deadline = 0;
  always @(negedge clk) begin : model
    bit idle, rd_ok, wr_ok;
    int win;
    #2;
    idle = !m_hold && !m_wait;
    win = !idle ? -1 : (bus.m0_req_valid && bus.m1_req_valid) ? (m_last == 1 ? 0 : 1)
        : bus.m0_req_valid ? 0 : bus.m1_req_valid ? 1 : -1;
    chk("model_hs", {bus.m0_req_ready, bus.m1_req_ready, bus.csb2nvdla_valid, busy},
        {win == 0, win == 1, m_hold, !idle});
    chk("model_csb", {bus.csb2nvdla_addr, bus.csb2nvdla_wdat, bus.csb2nvdla_write, bus.csb2nvdla_nposted},
        {m_addr, m_wdat, m_wr, m_np});
    chk("model_rsp0", {bus.m0_rsp_valid, bus.m0_rsp_data, bus.m0_rsp_err},
        {m_rsp_to == 0, m_rsp_to == 0 ? m_rd : 32'h0, m_rsp_to == 0 && m_re});
    chk("model_rsp1", {bus.m1_rsp_valid, bus.m1_rsp_data, bus.m1_rsp_err},
        {m_rsp_to == 1, m_rsp_to == 1 ? m_rd : 32'h0, m_rsp_to == 1 && m_re});
    chk("model_stray", stray_rsp, m_stray);
    if (reset) begin
      m_last = 1; m_owner = 0; m_rsp_to = -1; m_hold = 0; m_wait = 0;
      m_wr = 0; m_np = 0; m_re = 0; m_stray = 0; m_addr = '0; m_wdat = '0;
    end else begin
      rd_ok = m_wait && !m_wr && bus.nvdla2csb_valid;
      wr_ok = m_wait && m_wr && bus.nvdla2csb_wr_complete;
      if ((bus.nvdla2csb_valid && !rd_ok) || (bus.nvdla2csb_wr_complete && !wr_ok)) m_stray = 1;
      m_rsp_to = -1;
      if (win == 0) begin
        m_addr = bus.m0_req_addr; m_wdat = bus.m0_req_wdat; m_wr = bus.m0_req_write; m_np = bus.m0_req_nposted;
        m_owner = 0; m_last = 0; m_hold = 1;
      end else if (win == 1) begin
        m_addr = bus.m1_req_addr; m_wdat = bus.m1_req_wdat; m_wr = bus.m1_req_write; m_np = bus.m1_req_nposted;
        m_owner = 1; m_last = 1; m_hold = 1;
      end else if (m_hold && bus.csb2nvdla_ready) begin
        m_hold = 0;
        if (!(m_wr && !m_np)) begin m_wait = 1; m_deadline = cyc + T; end
      end else if (m_wait) begin
        if (rd_ok || wr_ok) begin
          m_rsp_to = m_owner; m_rd = rd_ok ? bus.nvdla2csb_data : 32'h0; m_re = 0; m_wait = 0;
        end else if (cyc == m_deadline) begin
          m_rsp_to = m_owner; m_rd = ERR; m_re = 1; m_wait = 0;
        end
      end
    end
    cyc++;
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic clr();
    bus.m0_req_valid = 0; bus.m0_req_addr = '0; bus.m0_req_wdat = '0; bus.m0_req_write = 0; bus.m0_req_nposted = 0;
    bus.m1_req_valid = 0; bus.m1_req_addr = '0; bus.m1_req_wdat = '0; bus.m1_req_write = 0; bus.m1_req_nposted = 0;
    bus.csb2nvdla_ready = 0; bus.nvdla2csb_valid = 0; bus.nvdla2csb_data = '0; bus.nvdla2csb_wr_complete = 0;
  endtask
  task automatic do_reset();
    tick(); reset = 1; clr();
    tick(); reset = 0;
  endtask
  initial begin
    int n0, n1, g[$];
    bit chk_next, early;
    logic [15:0] exp_addr;
    clr();
    // reset state and a simple read for m0
    tick(); reset = 0;
    #3 chk("rst_outputs", {busy, stray_rsp, bus.csb2nvdla_valid, bus.m0_rsp_valid, bus.m1_rsp_valid}, 0);
    tick(); bus.m0_req_valid = 1; bus.m0_req_addr = 16'h0004; bus.csb2nvdla_ready = 1;
    #3 chk("t1_ready", {bus.m0_req_ready, bus.m1_req_ready}, 2'b10);
    tick(); bus.m0_req_valid = 0;
    #3 chk("t1_csb", {bus.csb2nvdla_valid, bus.csb2nvdla_addr, bus.csb2nvdla_write}, {1'b1, 16'h0004, 1'b0});
    tick(); tick(); tick(); bus.nvdla2csb_valid = 1; bus.nvdla2csb_data = 32'h1234_5678;
    tick(); bus.nvdla2csb_valid = 0;
    #3 chk("t1_rsp0", {bus.m0_rsp_valid, bus.m0_rsp_data, bus.m0_rsp_err}, {1'b1, 32'h1234_5678, 1'b0});
    chk("t1_rsp1", {bus.m1_rsp_valid, bus.m1_rsp_data, bus.m1_rsp_err}, 0);
    tick();
    #3 chk("t1_rsp_once", bus.m0_rsp_valid, 0);
    // both requesters with three posted writes each alternate from reset
    do_reset();
    n0 = 0; n1 = 0; chk_next = 0; exp_addr = '0;
    for (int c = 0; c < 40 && (n0 < 3 || n1 < 3); c++) begin
      tick();
      bus.csb2nvdla_ready = 1;
      bus.m0_req_valid = n0 < 3; bus.m0_req_addr = 16'h0100 + 16'(n0); bus.m0_req_wdat = 32'hA000_0000 + 32'(n0);
      bus.m0_req_write = 1;
      bus.m1_req_valid = n1 < 3; bus.m1_req_addr = 16'h0200 + 16'(n1); bus.m1_req_wdat = 32'hB000_0000 + 32'(n1);
      bus.m1_req_write = 1;
      #3;
      if (chk_next) chk("t2_csb_follow", {bus.csb2nvdla_valid, bus.csb2nvdla_addr}, {1'b1, exp_addr});
      chk_next = 0;
      if (bus.m0_req_ready) begin g.push_back(0); n0++; chk_next = 1; exp_addr = bus.m0_req_addr; end
      if (bus.m1_req_ready) begin g.push_back(1); n1++; chk_next = 1; exp_addr = bus.m1_req_addr; end
    end
    tick(); clr(); bus.csb2nvdla_ready = 1;
    #3 if (chk_next) chk("t2_csb_follow", {bus.csb2nvdla_valid, bus.csb2nvdla_addr}, {1'b1, exp_addr});
    chk("t2_grant_count", g.size(), 6);
    foreach (g[i]) chk("t2_grant_order", g[i], i % 2);
    // m1 non-posted write times out, then a late completion is stray
    do_reset();
    tick(); bus.m1_req_valid = 1; bus.m1_req_addr = 16'h0030; bus.m1_req_wdat = 32'h55;
    bus.m1_req_write = 1; bus.m1_req_nposted = 1; bus.csb2nvdla_ready = 1;
    #3 chk("t3_ready1", bus.m1_req_ready, 1);
    tick(); bus.m1_req_valid = 0;
    #3 chk("t3_csb", {bus.csb2nvdla_valid, bus.csb2nvdla_nposted}, 2'b11);
    early = 0;
    for (int k = 0; k < T; k++) begin tick(); #3 if (bus.m1_rsp_valid) early = 1; end
    chk("t3_no_early", early, 0);
    tick();
    #3 chk("t3_rsp1", {bus.m1_rsp_valid, bus.m1_rsp_data, bus.m1_rsp_err}, {1'b1, ERR, 1'b1});
    chk("t3_rsp0", bus.m0_rsp_valid, 0);
    chk("t3_no_stray", stray_rsp, 0);
    repeat (4) tick();
    tick(); bus.nvdla2csb_wr_complete = 1;
    tick(); bus.nvdla2csb_wr_complete = 0;
    #3 chk("t3_stray", {stray_rsp, bus.m1_rsp_valid}, 2'b10);
    // CSB stalls for 10 cycles: fields hold, no new acceptance
    do_reset();
    tick(); bus.m0_req_valid = 1; bus.m0_req_addr = 16'h0ABC; bus.m0_req_wdat = 32'hCAFE_F00D; bus.m0_req_write = 1;
    #3 chk("t4_ready0", bus.m0_req_ready, 1);
    tick(); bus.m0_req_addr = 16'h1111; bus.m0_req_wdat = 32'h2222_3333; bus.m0_req_write = 0; bus.m0_req_nposted = 1;
    bus.m1_req_valid = 1; bus.m1_req_addr = 16'h4444;
    for (int i = 0; i < 10; i++) begin
      #3 chk("t4_hold", {bus.csb2nvdla_valid, bus.csb2nvdla_addr, bus.csb2nvdla_wdat, bus.csb2nvdla_write,
                         bus.csb2nvdla_nposted, bus.m0_req_ready, bus.m1_req_ready},
             {1'b1, 16'h0ABC, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 1'b0});
      tick();
    end
    bus.m0_req_valid = 0; bus.m1_req_valid = 0; bus.csb2nvdla_ready = 1;
    #3 chk("t4_issue", bus.csb2nvdla_valid, 1);
    tick(); bus.csb2nvdla_ready = 0;
    #3 chk("t4_posted_idle", {busy, bus.csb2nvdla_valid}, 0);
    // completion in the timeout cycle wins
    do_reset();
    tick(); bus.m0_req_valid = 1; bus.m0_req_addr = 16'h0040; bus.csb2nvdla_ready = 1;
    tick(); bus.m0_req_valid = 0;
    repeat (T - 1) tick();
    tick(); bus.nvdla2csb_valid = 1; bus.nvdla2csb_data = 32'h7777_1234;
    tick(); bus.nvdla2csb_valid = 0;
    #3 chk("t5_rsp0", {bus.m0_rsp_valid, bus.m0_rsp_data, bus.m0_rsp_err}, {1'b1, 32'h7777_1234, 1'b0});
    chk("t5_no_stray", stray_rsp, 0);
    // reset while waiting abandons the read; its late data is stray
    do_reset();
    tick(); bus.m1_req_valid = 1; bus.m1_req_addr = 16'h0050; bus.csb2nvdla_ready = 1;
    tick(); bus.m1_req_valid = 0;
    tick(); tick(); reset = 1;
    tick(); reset = 0;
    #3 chk("t6_idle", busy, 0);
    tick(); bus.nvdla2csb_valid = 1; bus.nvdla2csb_data = 32'h0BAD_0001;
    tick(); bus.nvdla2csb_valid = 0;
    #3 chk("t6_stray", stray_rsp, 1);
    chk("t6_quiet", {bus.m0_rsp_valid, bus.m1_rsp_valid, bus.m0_rsp_data, bus.m1_rsp_data, bus.m0_rsp_err,
                     bus.m1_rsp_err, bus.csb2nvdla_valid, bus.csb2nvdla_addr, bus.csb2nvdla_wdat,
                     bus.csb2nvdla_write, bus.csb2nvdla_nposted, busy, bus.m0_req_ready, bus.m1_req_ready}, 0);
    // random traffic against the model
    do_reset();
    repeat (3000) begin
      tick();
      reset = $urandom_range(0, 199) == 0;
      bus.m0_req_valid = $urandom_range(0, 2) != 0; bus.m0_req_addr = 16'($urandom); bus.m0_req_wdat = $urandom;
      bus.m0_req_write = 1'($urandom); bus.m0_req_nposted = 1'($urandom);
      bus.m1_req_valid = $urandom_range(0, 2) != 0; bus.m1_req_addr = 16'($urandom); bus.m1_req_wdat = $urandom;
      bus.m1_req_write = 1'($urandom); bus.m1_req_nposted = 1'($urandom);
      bus.csb2nvdla_ready = $urandom_range(0, 3) != 0;
      bus.nvdla2csb_valid = $urandom_range(0, 9) == 0; bus.nvdla2csb_data = $urandom;
      bus.nvdla2csb_wr_complete = $urandom_range(0, 9) == 0;
    end
    tick(); reset = 0; clr();
    tick(); tick();
    #3 $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/csb_arbiter.md
# csb_arbiter

Two-requester arbiter and sequencer for the NVDLA configuration space bus (CSB). It sits between the APB-to-CSB bridge (requester 0, host) and a local register-programming sequencer (requester 1), and the single CSB slave port of the NVDLA core. It serialises transactions with round-robin fairness and keeps at most one response-bearing transaction outstanding. It returns each read or non-posted-write response to the requester that issued it, with a response timeout.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: cycles in WAIT_RSP before an error response is forced; minimum 2.
- ERR_DATA, 32'hDEAD_0BAD: rsp_data returned on timeout.

Ports:
- clk  in  1  single clock; CSB and both requesters are synchronous to it.
- reset  in  1  synchronous, active-high reset.
- m0_req_valid / m1_req_valid  in  1  request valid.
- m0_req_ready / m1_req_ready  out  1  request accepted this cycle.
- m0_req_addr / m1_req_addr  in  16  CSB word address.
- m0_req_wdat / m1_req_wdat  in  32  write data.
- m0_req_write / m1_req_write  in  1  1 = write, 0 = read.
- m0_req_nposted / m1_req_nposted  in  1  write requires completion.
- m0_rsp_valid / m1_rsp_valid  out  1  one-cycle response pulse.
- m0_rsp_data / m1_rsp_data  out  32  read data; 0 for write completion; ERR_DATA on timeout.
- m0_rsp_err / m1_rsp_err  out  1  qualifies rsp_valid: timeout occurred.
- csb2nvdla_valid  out  1  CSB request valid.
- csb2nvdla_ready  in  1  CSB request accept.
- csb2nvdla_addr  out  16  CSB address.
- csb2nvdla_wdat  out  32  CSB write data.
- csb2nvdla_write  out  1  CSB write flag.
- csb2nvdla_nposted  out  1  CSB non-posted flag.
- nvdla2csb_valid  in  1  read data return.
- nvdla2csb_data  in  32  read data.
- nvdla2csb_wr_complete  in  1  non-posted write completion.
- stray_rsp  out  1  sticky: a response arrived with nothing outstanding.
- busy  out  1  state != IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ISSUE: drive CSB until csb2nvdla_ready.
  - WAIT_RSP: await read data or write completion.
- IDLE arbitration:
  - Single valid requester wins.
  - Both valid: the requester not in last_grant wins. last_grant resets to 1, so m0 wins the first tie.
  - mX_req_ready = (state==IDLE) & granted; it is combinational from the valid inputs.
- On acceptance:
  - Register addr, wdat, write and nposted into the CSB output registers.
  - owner <= winner; last_grant <= winner; go to ISSUE.
- ISSUE:
  - csb2nvdla_valid = 1. All CSB fields are held stable until csb2nvdla_ready.
  - On ready: a read or a non-posted write goes to WAIT_RSP with the timeout counter cleared.
  - On ready: a posted write goes to IDLE and produces no response.
- WAIT_RSP:
  - A read completes on nvdla2csb_valid; rsp_data = nvdla2csb_data.
  - A non-posted write completes on nvdla2csb_wr_complete; rsp_data = 0.
  - The counter increments every cycle. When it reaches TIMEOUT_CYCLES-1 without a completion, rsp_err = 1 and rsp_data = ERR_DATA.
  - Either outcome: pulse the owner's rsp_valid the next cycle (registered) and go to IDLE.
- Completion and timeout in the same cycle: the completion wins and rsp_err = 0.
- The wrong completion type, or any completion in IDLE or ISSUE, is dropped and sets stray_rsp. A late response after a timeout is handled the same way.
- Only the owner's rsp_valid ever pulses; the non-owner's rsp outputs stay 0.

## Timing
- Reset values:
  - All outputs 0: valid, ready, rsp_* and csb2nvdla_* fields.
  - state = IDLE, last_grant = 1, counter = 0, stray_rsp = 0.
- Request accept (cycle N) → csb2nvdla_valid at N+1. Minimum back-to-back posted-write rate is one per 2 cycles.
- Completion at cycle C → rsp_valid at C+1. The next request can be accepted at C+1 (IDLE).
- Timeout fires exactly TIMEOUT_CYCLES cycles after the ISSUE handshake cycle.
- Reset mid-transaction abandons it. No rsp_valid is issued for it, and the CSB valid drops at the next edge.

## Structure
- Shared package csb_pkg:
  - state enum {IDLE, ISSUE, WAIT_RSP}.
  - CSB_ADDR_W = 16, CSB_DATA_W = 32.
  - A csb_req_t struct {addr, wdat, write, nposted}.
- One sub-module, csb_rr_arb2: a 2-way round-robin grant with a last_grant register and an update enable.
- Timeout counter and response routing stay inline.

## Test plan
- m0 reads 16'h0004, CSB ready at once, data 32'h1234_5678 returned 3 cycles later → m0_rsp_valid one cycle after the return, data 32'h1234_5678, err 0; m1 rsp stays 0.
- m0 and m1 both request from reset, each with 3 posted writes → grants alternate m0, m1, m0, m1, m0, m1; csb2nvdla_valid per grant one cycle after ready.
- m1 non-posted write, wr_complete never asserted, TIMEOUT_CYCLES = 16 → m1_rsp_valid with err 1, data 32'hDEAD_0BAD, 16 cycles after the handshake. A wr_complete injected 5 cycles later sets stray_rsp.
- csb2nvdla_ready held low for 10 cycles during ISSUE → addr, wdat, write and nposted stay constant; no second request is accepted (both readys 0).
- Read outstanding, with nvdla2csb_valid in the same cycle the counter hits its limit → rsp err 0, real data.
- reset asserted in WAIT_RSP, then the response arrives after release → no rsp_valid, stray_rsp = 1, all outputs otherwise 0.
